// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64I decode types, opcodes and ALU-field decoding
package riscv_pkg;
  localparam int WIDTH = 64;
  localparam int REG_ADDR_W = 5;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_OP_32 = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_SLLW, ALU_SRLW, ALU_SRAW, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } op_alu_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    op_alu_e alu_op;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [WIDTH-1:0] imm;
    logic use_imm;
    logic use_pc;
    logic word;
    logic reg_write;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic [2:0] funct3;
    logic illegal;
  } decode_t;
  typedef struct packed {
    logic illegal;
    op_alu_e op;
  } alu_dec_t;
  function automatic alu_dec_t alu_decode(input logic [2:0] f3, input logic [6:0] f7, input logic word, input logic imm);
    logic base;
    logic alt;
    alu_dec_t r;
    base = imm ? f7[6:1] == 6'b000000 && !(word && f7[0]) : f7 == 7'b0000000;
    alt = imm ? f7[6:1] == 6'b010000 && !(word && f7[0]) : f7 == 7'b0100000;
    case (f3)
      3'b000: begin
        r.illegal = !imm && !(base || alt);
        r.op = !imm && alt ? ALU_SUB : ALU_ADD;
      end
      3'b001: begin
        r.illegal = !base;
        r.op = word ? ALU_SLLW : ALU_SLL;
      end
      3'b101: begin
        r.illegal = !(base || alt);
        r.op = alt ? (word ? ALU_SRAW : ALU_SRA) : (word ? ALU_SRLW : ALU_SRL);
      end
      default: begin
        r.illegal = word || (!imm && !base);
        r.op = f3 == 3'b010 ? ALU_SLT : f3 == 3'b011 ? ALU_SLTU : f3 == 3'b100 ? ALU_XOR : f3 == 3'b110 ? ALU_OR : ALU_AND;
      end
    endcase
    return r;
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate extraction for the RV base instruction formats
module imm_gen
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::WIDTH
) (
  input  logic [31:7]      instr_i,
  input  imm_fmt_e         fmt_i,
  output logic [WIDTH-1:0] imm_o
);
  always_comb
    imm_o = fmt_i == IMM_I ? {{(WIDTH-12){instr_i[31]}}, instr_i[31:20]}
          : fmt_i == IMM_S ? {{(WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]}
          : fmt_i == IMM_B ? {{(WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}
          : fmt_i == IMM_U ? {{(WIDTH-32){instr_i[31]}}, instr_i[31:12], 12'b0}
          : fmt_i == IMM_J ? {{(WIDTH-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}
          : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-entry RV64I decode pipeline register with valid/ready handshake
module decode_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output decode_t          out_dec
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_imm_op;
  logic is_word;
  logic is_shift;
  logic ill;
  imm_fmt_e fmt;
  logic [WIDTH-1:0] imm;
  alu_dec_t ad;
  decode_t dec_d;
  decode_t dec_q;
  logic valid_q;
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign is_imm_op = opc == OPC_OP_IMM || opc == OPC_OP_IMM_32;
  assign is_word = opc == OPC_OP_32 || opc == OPC_OP_IMM_32;
  assign is_shift = is_imm_op && f3[1:0] == 2'b01;
  assign ad = alu_decode(f3, f7, is_word, is_imm_op);
  always_comb
    fmt = opc inside {OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM} ? IMM_I
        : opc == OPC_STORE ? IMM_S
        : opc == OPC_BRANCH ? IMM_B
        : opc == OPC_LUI || opc == OPC_AUIPC ? IMM_U
        : opc == OPC_JAL ? IMM_J
        : IMM_NONE;
  imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr_i(in_instr[31:7]),
    .fmt_i  (fmt),
    .imm_o  (imm)
  );
  always_comb begin
    dec_d = '0;
    ill = 1'b0;
    dec_d.pc = in_pc;
    dec_d.rs1 = in_instr[19:15];
    dec_d.rs2 = in_instr[24:20];
    dec_d.rd = in_instr[11:7];
    dec_d.funct3 = f3;
    dec_d.word = is_word;
    case (opc)
      OPC_OP, OPC_OP_32: begin
        dec_d.alu_op = ad.op;
        dec_d.reg_write = 1'b1;
        ill = ad.illegal;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        dec_d.alu_op = ad.op;
        dec_d.use_imm = 1'b1;
        dec_d.reg_write = 1'b1;
        ill = ad.illegal;
      end
      OPC_BRANCH: begin
        dec_d.alu_op = f3 == 3'b000 ? ALU_EQ : f3 == 3'b001 ? ALU_NE : f3 == 3'b100 ? ALU_LT
                     : f3 == 3'b101 ? ALU_GE : f3 == 3'b110 ? ALU_LTU : ALU_GEU;
        dec_d.is_branch = 1'b1;
        ill = f3[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        dec_d.use_imm = 1'b1;
        dec_d.is_load = 1'b1;
        dec_d.reg_write = 1'b1;
        ill = f3 == 3'b111;
      end
      OPC_STORE: begin
        dec_d.use_imm = 1'b1;
        dec_d.is_store = 1'b1;
        ill = f3[2];
      end
      OPC_JALR: begin
        dec_d.use_imm = 1'b1;
        dec_d.is_jump = 1'b1;
        dec_d.reg_write = 1'b1;
        ill = f3 != 3'b000;
      end
      OPC_LUI: begin
        dec_d.rs1 = '0;
        dec_d.use_imm = 1'b1;
        dec_d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.use_imm = 1'b1;
        dec_d.use_pc = 1'b1;
        dec_d.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec_d.use_imm = 1'b1;
        dec_d.use_pc = 1'b1;
        dec_d.is_jump = 1'b1;
        dec_d.reg_write = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ill = 1'b0;
      default: ill = 1'b1;
    endcase
    dec_d.imm = is_shift ? (is_word ? WIDTH'(in_instr[24:20]) : WIDTH'(in_instr[25:20])) : imm;
    dec_d.illegal = ill;
    dec_d.alu_op = ill ? ALU_ADD : dec_d.alu_op;
    dec_d.reg_write = dec_d.reg_write && !ill && dec_d.rd != '0;
    dec_d.is_load = dec_d.is_load && !ill;
    dec_d.is_store = dec_d.is_store && !ill;
    dec_d.is_branch = dec_d.is_branch && !ill;
    dec_d.is_jump = dec_d.is_jump && !ill;
  end
  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= 1'b0;
      dec_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      dec_q <= dec_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  assign in_ready = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_dec = dec_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized decode-stage bench against an instruction-table reference model
module tb_decode_stage;
  import riscv_pkg::*;
  localparam int DW = $bits(decode_t);
  localparam int K_R = 0, K_I = 1, K_SH = 2, K_BR = 3, K_LD = 4, K_ST = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_JAL = 9, K_SYS = 10;
  localparam logic [31:0] MR = 32'hFE00707F, MI = 32'h0000707F, MS = 32'hFC00707F, MO = 32'h0000007F;
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    op_alu_e op;
    int kind;
    bit word;
  } ent_t;
  ent_t tab[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic flush = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  decode_t out_dec;
  logic m_valid = 1'b0;
  logic m_zero = 1'b0;
  decode_t m_dec = '0;
  int checks = 0;
  int errors = 0;
  decode_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dec  (out_dec)
  );
  always #5 clk = ~clk;
  task automatic add(input logic [31:0] mk, input logic [31:0] mt, input op_alu_e op, input int k, input bit w);
    tab.push_back('{mk, mt, op, k, w});
  endtask
  task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask
  function automatic logic [63:0] sx(input logic [31:0] raw, input int n);
    logic [63:0] t;
    t = 64'(1) << (n - 1);
    return ({32'b0, raw} ^ t) - t;
  endfunction
  function automatic decode_t model(input logic [31:0] ins, input logic [63:0] pc);
    decode_t d;
    ent_t e;
    int hit;
    hit = -1;
    foreach (tab[i]) if ((ins & tab[i].mask) == tab[i].match) hit = i;
    d = '0;
    d.pc = pc;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd = ins[11:7];
    d.funct3 = ins[14:12];
    if (hit < 0) begin
      d.illegal = 1'b1;
      return d;
    end
    e = tab[hit];
    d.alu_op = e.op;
    d.word = e.word;
    case (e.kind)
      K_R: d.reg_write = 1'b1;
      K_I: begin d.use_imm = 1'b1; d.reg_write = 1'b1; d.imm = sx(ins[31:20], 12); end
      K_SH: begin d.use_imm = 1'b1; d.reg_write = 1'b1; d.imm = e.word ? 64'(ins[24:20]) : 64'(ins[25:20]); end
      K_BR: begin d.is_branch = 1'b1; d.imm = sx({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13); end
      K_LD: begin d.use_imm = 1'b1; d.is_load = 1'b1; d.reg_write = 1'b1; d.imm = sx(ins[31:20], 12); end
      K_ST: begin d.use_imm = 1'b1; d.is_store = 1'b1; d.imm = sx({ins[31:25], ins[11:7]}, 12); end
      K_JALR: begin d.use_imm = 1'b1; d.is_jump = 1'b1; d.reg_write = 1'b1; d.imm = sx(ins[31:20], 12); end
      K_LUI: begin d.rs1 = '0; d.use_imm = 1'b1; d.reg_write = 1'b1; d.imm = sx({ins[31:12], 12'b0}, 32); end
      K_AUIPC: begin d.use_imm = 1'b1; d.use_pc = 1'b1; d.reg_write = 1'b1; d.imm = sx({ins[31:12], 12'b0}, 32); end
      K_JAL: begin d.use_imm = 1'b1; d.use_pc = 1'b1; d.is_jump = 1'b1; d.reg_write = 1'b1; d.imm = sx({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21); end
      default: d.imm = sx(ins[31:20], 12);
    endcase
    d.reg_write = d.reg_write && ins[11:7] != 5'd0;
    return d;
  endfunction
  always @(posedge clk)
    if (rst) begin
      m_valid <= 1'b0;
      m_dec <= '0;
      m_zero <= 1'b1;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_zero <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_dec <= model(in_instr, in_pc);
      m_zero <= 1'b0;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, !m_valid || out_ready);
    if (m_valid && m_dec.illegal)
      chk("dec_illegal", {out_dec.illegal, out_dec.reg_write, out_dec.pc}, {m_dec.illegal, m_dec.reg_write, m_dec.pc});
    else if (m_valid || m_zero)
      chk("dec", out_dec, m_dec);
  end
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [63:0] pc, input bit ordy, input bit fl);
    in_valid = v;
    in_instr = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k;
    logic [31:0] x;
    logic [31:0] ins;
    logic [31:0] hi;
    logic [31:0] lo;
    add(MR, 32'h00000033, ALU_ADD, K_R, 0);  add(MR, 32'h40000033, ALU_SUB, K_R, 0);
    add(MR, 32'h00001033, ALU_SLL, K_R, 0);  add(MR, 32'h00002033, ALU_SLT, K_R, 0);
    add(MR, 32'h00003033, ALU_SLTU, K_R, 0); add(MR, 32'h00004033, ALU_XOR, K_R, 0);
    add(MR, 32'h00005033, ALU_SRL, K_R, 0);  add(MR, 32'h40005033, ALU_SRA, K_R, 0);
    add(MR, 32'h00006033, ALU_OR, K_R, 0);   add(MR, 32'h00007033, ALU_AND, K_R, 0);
    add(MR, 32'h0000003B, ALU_ADD, K_R, 1);  add(MR, 32'h4000003B, ALU_SUB, K_R, 1);
    add(MR, 32'h0000103B, ALU_SLLW, K_R, 1); add(MR, 32'h0000503B, ALU_SRLW, K_R, 1);
    add(MR, 32'h4000503B, ALU_SRAW, K_R, 1);
    add(MI, 32'h00000013, ALU_ADD, K_I, 0);  add(MI, 32'h00002013, ALU_SLT, K_I, 0);
    add(MI, 32'h00003013, ALU_SLTU, K_I, 0); add(MI, 32'h00004013, ALU_XOR, K_I, 0);
    add(MI, 32'h00006013, ALU_OR, K_I, 0);   add(MI, 32'h00007013, ALU_AND, K_I, 0);
    add(MI, 32'h0000001B, ALU_ADD, K_I, 1);
    add(MS, 32'h00001013, ALU_SLL, K_SH, 0); add(MS, 32'h00005013, ALU_SRL, K_SH, 0);
    add(MS, 32'h40005013, ALU_SRA, K_SH, 0);
    add(MR, 32'h0000101B, ALU_SLLW, K_SH, 1); add(MR, 32'h0000501B, ALU_SRLW, K_SH, 1);
    add(MR, 32'h4000501B, ALU_SRAW, K_SH, 1);
    add(MI, 32'h00000063, ALU_EQ, K_BR, 0);  add(MI, 32'h00001063, ALU_NE, K_BR, 0);
    add(MI, 32'h00004063, ALU_LT, K_BR, 0);  add(MI, 32'h00005063, ALU_GE, K_BR, 0);
    add(MI, 32'h00006063, ALU_LTU, K_BR, 0); add(MI, 32'h00007063, ALU_GEU, K_BR, 0);
    for (int f = 0; f < 7; f++) add(MI, 32'h00000003 | (f << 12), ALU_ADD, K_LD, 0);
    for (int f = 0; f < 4; f++) add(MI, 32'h00000023 | (f << 12), ALU_ADD, K_ST, 0);
    add(MI, 32'h00000067, ALU_ADD, K_JALR, 0);
    add(MO, 32'h00000037, ALU_ADD, K_LUI, 0);  add(MO, 32'h00000017, ALU_ADD, K_AUIPC, 0);
    add(MO, 32'h0000006F, ALU_ADD, K_JAL, 0);  add(MO, 32'h0000000F, ALU_ADD, K_SYS, 0);
    add(MO, 32'h00000073, ALU_ADD, K_SYS, 0);
    rst = 1'b1;
    cyc(0, 32'h0, 64'h0, 0, 0);
    cyc(0, 32'h0, 64'h0, 0, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_dec", out_dec, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    cyc(1, 32'h00500093, 64'h1000, 1, 0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_alu", out_dec.alu_op, ALU_ADD);
    chk("addi_rd", out_dec.rd, 5'd1);
    chk("addi_rs1", out_dec.rs1, 5'd0);
    chk("addi_imm", out_dec.imm, 64'd5);
    chk("addi_use_imm", out_dec.use_imm, 1'b1);
    chk("addi_reg_write", out_dec.reg_write, 1'b1);
    cyc(1, 32'h402081B3, 64'h1004, 1, 0);
    chk("sub_alu", out_dec.alu_op, ALU_SUB);
    chk("sub_rs1", out_dec.rs1, 5'd1);
    chk("sub_rs2", out_dec.rs2, 5'd2);
    chk("sub_rd", out_dec.rd, 5'd3);
    chk("sub_use_imm", out_dec.use_imm, 1'b0);
    cyc(1, 32'hFE208CE3, 64'h1008, 1, 0);
    chk("beq_alu", out_dec.alu_op, ALU_EQ);
    chk("beq_is_branch", out_dec.is_branch, 1'b1);
    chk("beq_imm", out_dec.imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_reg_write", out_dec.reg_write, 1'b0);
    cyc(1, 32'h00A00113, 64'h2000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h00B00193, 64'h2004, 0, 0);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_pc", out_dec.pc, 64'h2000);
      chk("stall_imm", out_dec.imm, 64'd10);
    end
    cyc(1, 32'h00B00193, 64'h2004, 1, 0);
    chk("release_pc", out_dec.pc, 64'h2004);
    chk("release_imm", out_dec.imm, 64'd11);
    cyc(0, 32'h0, 64'h0, 1, 0);
    chk("release_no_dup", out_valid, 1'b0);
    cyc(1, 32'h00C00213, 64'h3000, 0, 0);
    chk("pre_flush_valid", out_valid, 1'b1);
    cyc(1, 32'h00D00293, 64'h3004, 0, 1);
    chk("flush_valid", out_valid, 1'b0);
    cyc(1, 32'h00000000, 64'h3008, 1, 0);
    chk("zero_valid", out_valid, 1'b1);
    chk("zero_illegal", out_dec.illegal, 1'b1);
    chk("zero_reg_write", out_dec.reg_write, 1'b0);
    cyc(1, 32'h00E00313, 64'h4000, 1, 0);
    rst = 1'b1;
    cyc(1, 32'h00F00393, 64'h4004, 0, 0);
    chk("rst_stall_valid", out_valid, 1'b0);
    chk("rst_stall_dec", out_dec, '0);
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        k = $urandom_range(0, tab.size() - 1);
        x = $urandom;
        ins = (tab[k].match & tab[k].mask) | (x & ~tab[k].mask);
      end else begin
        ins = $urandom;
      end
      hi = $urandom;
      lo = $urandom;
      rst = $urandom_range(0, 99) == 0;
      cyc($urandom_range(0, 3) != 0, ins, {hi, lo}, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 64'h0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WIDTH, default riscv_pkg::WIDTH (64), datapath/PC width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  fetch presents instruction.
REQ-005 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have port in_instr  input  32  raw instruction.
REQ-007 SHALL have port in_pc  input  WIDTH  instruction address.
REQ-008 SHALL have port flush  input  1  kill held and incoming instruction.
REQ-009 SHALL have port out_valid  output  1  decoded bundle valid to execute stage.
REQ-010 SHALL have port out_ready  input  1  execute stage accepts.
REQ-011 SHALL have port out_dec  output  decode_t  decoded bundle: pc, alu_op (op_alu_e), rs1, rs2, rd (REG_ADDR_W each), imm (WIDTH), use_imm, use_pc, word, reg_write, is_load, is_store, is_branch, is_jump, funct3, illegal.

Function
REQ-012 SHALL register one decoded instruction; latency in-accept to out_valid exactly 1 cycle.
REQ-013 SHALL drive in_ready = !out_valid || out_ready (combinational, no bubble at full throughput).
REQ-014 SHALL capture on in_valid && in_ready && !flush; out_valid set next cycle.
REQ-015 SHALL clear out_valid when out_valid && out_ready and no new capture.
REQ-016 SHALL hold out_dec and out_valid stable while out_valid && !out_ready.
REQ-017 SHALL, on flush, clear out_valid next cycle and drop any same-cycle input; flush overrides capture and hold.
REQ-018 SHALL decode OPCODE_OP_64/OP_32 by funct3/funct7 to ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (SLLW/SRLW/SRAW for OP_32); word=1 for OP_32/OP_IMM_32.
REQ-019 SHALL decode OP_IMM_64/OP_IMM_32 likewise with use_imm=1; shamt 6 bits (64) / 5 bits (32); SUB-form or shamt[5]=1 in OP_IMM_32 sets illegal.
REQ-020 SHALL decode BRANCH funct3 000/001/100/101/110/111 to ALU_EQ/NE/LT/GE/LTU/GEU, is_branch=1, reg_write=0; funct3 010/011 illegal.
REQ-021 SHALL decode LOAD/STORE as ALU_ADD, use_imm=1, is_load/is_store; LUI as ALU_ADD with rs1 forced 0; AUIPC and JAL as ALU_ADD with use_pc=1; JALR as ALU_ADD use_imm=1; JAL/JALR is_jump=1.
REQ-022 SHALL sign-extend imm to WIDTH per I/S/B/U/J format; U-format bits [31:12] then sign-extended.
REQ-023 SHALL set illegal=1, reg_write=0 for any unlisted opcode/funct combination; FENCE and SYSTEM decode as ALU_ADD, reg_write=0, no illegal.
REQ-024 SHALL force reg_write=0 when rd=0.

Reset
REQ-025 SHALL, with rst high at a clock edge, set out_valid=0 and out_dec all-zero; in_ready=1 the following cycle.
REQ-026 SHALL give rst priority over flush and capture; an instruction held mid-stall is discarded.

Structure
REQ-027 SHALL place decode_t struct and imm_fmt_e enum (I,S,B,U,J,NONE) in riscv_pkg.
REQ-028 SHALL instantiate one combinational sub-module imm_gen (in_instr, imm_fmt_e -> WIDTH imm).

Verification
REQ-029 SHALL check 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, ALU_ADD, rd=1, rs1=0, imm=5, use_imm=1, reg_write=1.
REQ-030 SHALL check 0x402081B3 (sub x3,x1,x2) -> ALU_SUB, rs1=1, rs2=2, rd=3, use_imm=0.
REQ-031 SHALL check beq with offset -8 -> ALU_EQ, is_branch=1, imm=0xFFFF_FFFF_FFFF_FFF8, reg_write=0.
REQ-032 SHALL hold out_ready=0 three cycles with in_valid=1 -> in_ready=0, out_dec unchanged, no instruction lost or duplicated after release.
REQ-033 SHALL assert flush with in_valid=1 and a held instruction -> out_valid=0 next cycle; 0x00000000 input -> illegal=1.
REQ-034 SHALL assert rst during stall -> out_valid=0 and out_dec=0 next cycle.
